// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard/control block:
// ARM condition codes, forwarding selects, ALU flag bit positions.
package pipe_ctrl_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  // aluflags layout is {CO, OVF, N, Z}
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 3;

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic       memtoreg;
    logic       branch;
    logic       pcsrc;
    logic       flagwrite;
    logic [3:0] cond;
  } ectrl_t;

  typedef struct packed {
    logic regwrite;
    logic memwrite;
    logic memtoreg;
    logic pcsrc;
  } mctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic pcsrc;
  } wctrl_t;

  function automatic logic [1:0] fwd_sel(input logic [3:0] ra,
                                         input logic       rw_m,
                                         input logic [3:0] wa_m,
                                         input logic       rw_w,
                                         input logic [3:0] wa_w);
    logic [1:0] sel;
    if (rw_m && (ra == wa_m)) begin
      sel = FWD_M;
    end else if (rw_w && (ra == wa_w)) begin
      sel = FWD_W;
    end else begin
      sel = FWD_REG;
    end
    return sel;
  endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluation against the stored {C,V,N,Z} flags.
module cond_check
  import pipe_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       condex
);

  logic z, n, v, c;

  always_comb begin
    z      = flags[FLAG_Z];
    n      = flags[FLAG_N];
    v      = flags[FLAG_V];
    c      = flags[FLAG_C];
    condex = 1'b0;
    case (cond)
      COND_EQ: condex = z;
      COND_NE: condex = ~z;
      COND_CS: condex = c;
      COND_CC: condex = ~c;
      COND_MI: condex = n;
      COND_PL: condex = ~n;
      COND_VS: condex = v;
      COND_VC: condex = ~v;
      COND_HI: condex = c & ~z;
      COND_LS: condex = ~c | z;
      COND_GE: condex = ~(n ^ v);
      COND_LT: condex = n ^ v;
      COND_GT: condex = ~z & ~(n ^ v);
      COND_LE: condex = z | (n ^ v);
      COND_AL: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// E/M/W control pipeline with conditional-execution gating, plus the hazard unit
// (forwarding, load-use stall, PC-write and branch flushes) and saturating event counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             regwrited,
  input  logic             memwrited,
  input  logic             memtoregd,
  input  logic             branchd,
  input  logic             pcsrcd,
  input  logic             flagwrited,
  input  logic [3:0]       condd,
  input  logic [3:0]       ra1dp,
  input  logic [3:0]       ra2dp,
  input  logic [3:0]       ra1ep,
  input  logic [3:0]       ra2ep,
  input  logic [3:0]       wa3ep,
  input  logic [3:0]       wa3mp,
  input  logic [3:0]       wa3wp,
  input  logic [3:0]       aluflags,
  output logic             regwritew,
  output logic             memtoregw,
  output logic             pcsrcw,
  output logic             wemwritem,
  output logic             branchtakene,
  output logic             stallf,
  output logic             stalld,
  output logic             flushd,
  output logic             flushe,
  output logic [1:0]       forwardae,
  output logic [1:0]       forwardbe,
  output logic [CNT_W-1:0] stallcount,
  output logic [CNT_W-1:0] flushcount
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ectrl_t           e_q, e_d;
  mctrl_t           m_q, m_d;
  wctrl_t           w_q, w_d;
  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             condexe;
  logic             ldrstall;
  logic             pcwrpend;

  cond_check u_cond_check (
    .cond   (e_q.cond),
    .flags  (flags_q),
    .condex (condexe)
  );

  // Reset masks everything that depends on E/M/W state, since that state has not cleared yet.
  always_comb begin
    ldrstall     = ~reset & e_q.memtoreg & e_q.regwrite & ((ra1dp == wa3ep) | (ra2dp == wa3ep));
    branchtakene = ~reset & e_q.branch & condexe;
    pcwrpend     = pcsrcd | (~reset & ((e_q.pcsrc & condexe) | m_q.pcsrc));
    stallf       = ldrstall | pcwrpend;
    stalld       = ldrstall;
    flushd       = pcwrpend | (~reset & w_q.pcsrc) | branchtakene;
    flushe       = ldrstall | branchtakene;
    forwardae    = FWD_REG;
    forwardbe    = FWD_REG;
    if (!reset) begin
      forwardae = fwd_sel(ra1ep, m_q.regwrite, wa3mp, w_q.regwrite, wa3wp);
      forwardbe = fwd_sel(ra2ep, m_q.regwrite, wa3mp, w_q.regwrite, wa3wp);
    end else begin
      forwardae = FWD_REG;
      forwardbe = FWD_REG;
    end
  end

  always_comb begin
    e_d = '0;
    if (!flushe) begin
      e_d.regwrite  = regwrited;
      e_d.memwrite  = memwrited;
      e_d.memtoreg  = memtoregd;
      e_d.branch    = branchd;
      e_d.pcsrc     = pcsrcd;
      e_d.flagwrite = flagwrited;
      e_d.cond      = condd;
    end else begin
      e_d = '0;
    end

    m_d.regwrite = e_q.regwrite & condexe;
    m_d.memwrite = e_q.memwrite & condexe;
    m_d.memtoreg = e_q.memtoreg;
    m_d.pcsrc    = e_q.pcsrc & condexe;

    w_d.regwrite = m_q.regwrite;
    w_d.memtoreg = m_q.memtoreg;
    w_d.pcsrc    = m_q.pcsrc;

    flags_d = (e_q.flagwrite & condexe) ? aluflags : flags_q;

    stall_cnt_d = (stallf && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_ONE : stall_cnt_q;
    flush_cnt_d = ((flushd | flushe) && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_ONE : flush_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q         <= '0;
      m_q         <= '0;
      w_q         <= '0;
      flags_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      m_q         <= m_d;
      w_q         <= w_d;
      flags_q     <= flags_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign regwritew  = w_q.regwrite;
  assign memtoregw  = w_q.memtoreg;
  assign pcsrcw     = w_q.pcsrc;
  assign wemwritem  = m_q.memwrite;
  assign stallcount = stall_cnt_q;
  assign flushcount = flush_cnt_q;

endmodule
